// File: rtl/cc_seq_pkg.sv
// Shared encodings and defaults for the microprogram sequencer.
package cc_seq_pkg;

    localparam logic [1:0] SEL_NEXT    = 2'b00;
    localparam logic [1:0] SEL_JUMP    = 2'b01;
    localparam logic [1:0] SEL_DECODE  = 2'b10;
    localparam logic [1:0] SEL_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_e;

    localparam logic [10:0] DEFAULT_RESET_VECTOR = 11'd0;
    localparam logic [10:0] DEFAULT_TRAP_VECTOR  = 11'd2047;
    localparam logic        DECODE_PREFIX        = 1'b1;

endpackage

// File: rtl/cc_micro_addr_mux.sv
// Combinational next micro-address selection: sequential, jump, opcode decode or trap.
module cc_micro_addr_mux
    import cc_seq_pkg::*;
#(
    parameter int                        DATAWIDTH_ADDR = 11,
    parameter int                        DATAWIDTH_SEL  = 2,
    parameter logic [DATAWIDTH_ADDR-1:0] TRAP_VECTOR    = DEFAULT_TRAP_VECTOR
) (
    input  logic [DATAWIDTH_SEL-1:0]  i_sel,
    input  logic [DATAWIDTH_ADDR-1:0] i_cur_addr,
    input  logic [DATAWIDTH_ADDR-1:0] i_jump_addr,
    input  logic [1:0]                i_ir_op,
    input  logic [5:0]                i_ir_op3,
    output logic [DATAWIDTH_ADDR-1:0] o_next_addr,
    output logic                      o_illegal
);

    logic [DATAWIDTH_ADDR-1:0] w_decode_addr;

    // Each opcode owns a 4-word slot in the upper half of the control store.
    assign w_decode_addr = DATAWIDTH_ADDR'({DECODE_PREFIX, i_ir_op, i_ir_op3, 2'b00});

    always_comb begin
        o_next_addr = i_cur_addr + 1'b1;
        o_illegal   = 1'b0;
        case (i_sel)
            SEL_NEXT:   o_next_addr = i_cur_addr + 1'b1;
            SEL_JUMP:   o_next_addr = i_jump_addr;
            SEL_DECODE: o_next_addr = w_decode_addr;
            default: begin
                o_next_addr = TRAP_VECTOR;
                o_illegal   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cc_micro_sequencer.sv
// Micro-PC, issue FSM, reset synchroniser, sticky illegal-select flag and advance counter.
module cc_micro_sequencer
    import cc_seq_pkg::*;
#(
    parameter int                        DATAWIDTH_ADDR  = 11,
    parameter int                        DATAWIDTH_SEL   = 2,
    parameter int                        DATAWIDTH_COUNT = 16,
    parameter logic [DATAWIDTH_ADDR-1:0] RESET_VECTOR    = DEFAULT_RESET_VECTOR,
    parameter logic [DATAWIDTH_ADDR-1:0] TRAP_VECTOR     = DEFAULT_TRAP_VECTOR
) (
    input  logic                       Seq_CLOCK_50,
    input  logic                       Seq_RESET_InLow,
    input  logic [DATAWIDTH_SEL-1:0]   Seq_Select,
    input  logic [DATAWIDTH_ADDR-1:0]  Seq_JumpAddr,
    input  logic [1:0]                 Seq_IrOp,
    input  logic [5:0]                 Seq_IrOp3,
    input  logic                       Seq_MemReady,
    input  logic                       Seq_Halt,
    output logic [DATAWIDTH_ADDR-1:0]  Seq_Addr,
    output logic                       Seq_AddrValid,
    output logic [1:0]                 Seq_State,
    output logic                       Seq_IllegalSel,
    output logic [DATAWIDTH_COUNT-1:0] Seq_CycleCount
);

    logic [1:0]                 r_rst_sync;
    seq_state_e                 r_state;
    logic [DATAWIDTH_ADDR-1:0]  r_addr;
    logic                       r_addr_valid;
    logic                       r_illegal;
    logic [DATAWIDTH_COUNT-1:0] r_count;

    seq_state_e                 w_next_state;
    logic                       w_advance;
    logic [DATAWIDTH_ADDR-1:0]  w_mux_addr;
    logic                       w_mux_illegal;

    cc_micro_addr_mux #(
        .DATAWIDTH_ADDR (DATAWIDTH_ADDR),
        .DATAWIDTH_SEL  (DATAWIDTH_SEL),
        .TRAP_VECTOR    (TRAP_VECTOR)
    ) u_addr_mux (
        .i_sel       (Seq_Select),
        .i_cur_addr  (r_addr),
        .i_jump_addr (Seq_JumpAddr),
        .i_ir_op     (Seq_IrOp),
        .i_ir_op3    (Seq_IrOp3),
        .o_next_addr (w_mux_addr),
        .o_illegal   (w_mux_illegal)
    );

    // Assertion is immediate; release only reaches the FSM two edges later.
    always_ff @(posedge Seq_CLOCK_50 or negedge Seq_RESET_InLow) begin
        if (!Seq_RESET_InLow) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_advance    = 1'b0;
        case (r_state)
            ST_RESET: begin
                if (r_rst_sync[1]) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (Seq_Halt) begin
                    w_next_state = ST_HALT;
                end else if (!Seq_MemReady) begin
                    w_next_state = ST_STALL;
                end else begin
                    w_advance = 1'b1;
                end
            end
            ST_STALL: begin
                if (Seq_Halt) begin
                    w_next_state = ST_HALT;
                end else if (Seq_MemReady) begin
                    w_next_state = ST_RUN;
                    w_advance    = 1'b1;
                end
            end
            ST_HALT: begin
                if (!Seq_Halt) begin
                    w_next_state = ST_RUN;
                end
            end
            default: w_next_state = ST_RESET;
        endcase
    end

    always_ff @(posedge Seq_CLOCK_50 or negedge Seq_RESET_InLow) begin
        if (!Seq_RESET_InLow) begin
            r_state      <= ST_RESET;
            r_addr       <= RESET_VECTOR;
            r_addr_valid <= 1'b0;
            r_illegal    <= 1'b0;
            r_count      <= '0;
        end else begin
            r_state      <= w_next_state;
            r_addr_valid <= (w_next_state == ST_RUN) || (w_next_state == ST_STALL);
            if (w_advance) begin
                r_addr <= w_mux_addr;
                if (w_mux_illegal) begin
                    r_illegal <= 1'b1;
                end
                if (r_count != {DATAWIDTH_COUNT{1'b1}}) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign Seq_Addr       = r_addr;
    assign Seq_AddrValid  = r_addr_valid;
    assign Seq_State      = r_state;
    assign Seq_IllegalSel = r_illegal;
    assign Seq_CycleCount = r_count;

endmodule

// File: tb/tb_cc_micro_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_cc_micro_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  sel;
    logic [10:0] jmp;
    logic [1:0]  irop;
    logic [5:0]  irop3;
    logic        rdy;
    logic        hlt;
    logic [10:0] addr;
    logic        addr_valid;
    logic [1:0]  state;
    logic        illegal;
    logic [15:0] count;

    typedef struct {
        logic [10:0] addr;
        logic        valid;
        logic [1:0]  st;
        logic        ill;
        logic [15:0] cnt;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    event ev_async;

    localparam logic [1:0] S_RESET = 2'd0, S_RUN = 2'd1, S_STALL = 2'd2, S_HALT = 2'd3;

    always #5 clk = ~clk;

    cc_micro_sequencer dut (
        .Seq_CLOCK_50   (clk),
        .Seq_RESET_InLow(rst_n),
        .Seq_Select     (sel),
        .Seq_JumpAddr   (jmp),
        .Seq_IrOp       (irop),
        .Seq_IrOp3      (irop3),
        .Seq_MemReady   (rdy),
        .Seq_Halt       (hlt),
        .Seq_Addr       (addr),
        .Seq_AddrValid  (addr_valid),
        .Seq_State      (state),
        .Seq_IllegalSel (illegal),
        .Seq_CycleCount (count)
    );

    // Monitor: one popped expectation per clock edge (or asynchronous event).
    initial begin
        forever begin
            @(posedge clk or ev_async);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if ({addr, addr_valid, state, illegal, count} !== {e.addr, e.valid, e.st, e.ill, e.cnt}) begin
                    failures++;
                    $display("FAIL %s: got addr=%0d valid=%0b state=%0d ill=%0b cnt=%0d, want addr=%0d valid=%0b state=%0d ill=%0b cnt=%0d",
                             e.nm, addr, addr_valid, state, illegal, count,
                             e.addr, e.valid, e.st, e.ill, e.cnt);
                end else begin
                    $display("ok   %s: addr=%0d valid=%0b state=%0d ill=%0b cnt=%0d",
                             e.nm, addr, addr_valid, state, illegal, count);
                end
            end
        end
    end

    task automatic push(input logic [10:0] ea, input logic ev, input logic [1:0] es,
                        input logic ei, input logic [15:0] ec, input string nm);
        exp_t e;
        e.addr = ea; e.valid = ev; e.st = es; e.ill = ei; e.cnt = ec; e.nm = nm;
        q.push_back(e);
    endtask

    // Drive one cycle of inputs at the falling edge; expectation is for after the next rising edge.
    task automatic step(input logic [1:0] s, input logic [10:0] j, input logic [1:0] op,
                        input logic [5:0] op3, input logic r, input logic h,
                        input logic [10:0] ea, input logic ev, input logic [1:0] es,
                        input logic ei, input logic [15:0] ec, input string nm);
        sel = s; jmp = j; irop = op; irop3 = op3; rdy = r; hlt = h;
        push(ea, ev, es, ei, ec, nm);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; sel = 2'b00; jmp = '0; irop = '0; irop3 = '0; rdy = 1'b1; hlt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step(2'b00, 0, 0, 0, 1, 0,    0, 0, S_RESET, 0, 0, "reset_held");

        // Release: two synchroniser edges, one RESET edge, then RUN at the reset vector.
        rst_n = 1'b1;
        step(2'b00, 0, 0, 0, 1, 0,    0, 0, S_RESET, 0, 0, "release_a");
        step(2'b00, 0, 0, 0, 1, 0,    0, 0, S_RESET, 0, 0, "release_b");
        step(2'b00, 0, 0, 0, 1, 0,    0, 1, S_RUN,   0, 0, "first_run");
        step(2'b00, 0, 0, 0, 1, 0,    1, 1, S_RUN,   0, 1, "seq_1");
        step(2'b00, 0, 0, 0, 1, 0,    2, 1, S_RUN,   0, 2, "seq_2");
        step(2'b00, 0, 0, 0, 1, 0,    3, 1, S_RUN,   0, 3, "seq_3");

        step(2'b01, 2047, 0, 0, 1, 0, 2047, 1, S_RUN, 0, 4, "jump_2047");
        step(2'b00, 0, 0, 0, 1, 0,    0, 1, S_RUN,   0, 5, "wrap_to_0");
        step(2'b01, 1234, 0, 0, 1, 0, 1234, 1, S_RUN, 0, 6, "jump_1234");
        step(2'b10, 0, 2'b10, 6'b010000, 1, 0, 1600, 1, S_RUN, 0, 7, "decode_1600");
        step(2'b11, 0, 0, 0, 1, 0,    2047, 1, S_RUN, 1, 8, "illegal_trap");
        step(2'b00, 0, 0, 0, 1, 0,    0, 1, S_RUN,   1, 9, "illegal_sticky");
        step(2'b01, 5, 0, 0, 1, 0,    5, 1, S_RUN,   1, 10, "jump_5");

        // Stall with a pending jump: address must hold until ready returns.
        step(2'b01, 9, 0, 0, 0, 0,    5, 1, S_STALL, 1, 10, "stall_1");
        step(2'b01, 9, 0, 0, 0, 0,    5, 1, S_STALL, 1, 10, "stall_2");
        step(2'b01, 9, 0, 0, 0, 0,    5, 1, S_STALL, 1, 10, "stall_3");
        step(2'b01, 9, 0, 0, 1, 0,    9, 1, S_RUN,   1, 11, "stall_exit");

        // Halt wins over ready; release gives one RUN cycle with no advance.
        step(2'b00, 0, 0, 0, 1, 1,    9, 0, S_HALT,  1, 11, "halt_1");
        step(2'b00, 0, 0, 0, 1, 1,    9, 0, S_HALT,  1, 11, "halt_2");
        step(2'b00, 0, 0, 0, 1, 0,    9, 1, S_RUN,   1, 11, "halt_release");
        step(2'b00, 0, 0, 0, 1, 0,    10, 1, S_RUN,  1, 12, "post_halt_adv");

        step(2'b00, 0, 0, 0, 0, 0,    10, 1, S_STALL, 1, 12, "stall_pre_rst");
        // Asynchronous reset mid-cycle, checked before any clock edge.
        #2;
        rst_n = 1'b0;
        push(0, 0, S_RESET, 0, 0, "async_reset");
        -> ev_async;
        @(negedge clk);
        step(2'b00, 0, 0, 0, 1, 0,    0, 0, S_RESET, 0, 0, "reset_hold2");

        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        if (q.size() != 0) begin
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + ((q.size() != 0) ? 1 : 0));
        $finish;
    end

endmodule
